seg_display_ctrl: RTL
=====================

# seg_display_ctrl

Sequential front-end for the three-digit seven-segment readout. It accepts a W-bit unsigned value over a valid/ready handshake and converts it to three BCD digits with an iterative shift-and-add-3 (double-dabble) engine, one shift per clock. It then updates all three active-low segment outputs atomically, with optional leading-zero blanking. It replaces per-cycle combinational divide/modulo digit extraction between the datapath value and the board displays.

## Interface
- W, 8, input value width; legal range 4..9, so the maximum value is 999 or less.
- BLANK_LZ, 1, 1 = blank leading zero digits; 0 = always show three digits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  W  unsigned value to display; sampled only on handshake.
- in_ready  out  1  block can accept a value (state IDLE).
- busy  out  1  conversion in progress (state SHIFT or UPDATE).
- done  out  1  one-cycle pulse, coincident with the display update.
- display1  out  7  ones digit, active-low, bit order {g,f,e,d,c,b,a}.
- display2  out  7  tens digit, same encoding.
- display3  out  7  hundreds digit, same encoding.

## Operation
- Segment codes for digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank is 1111111.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: bin_sr <= in_data, bcd <= 0 (12 bits), cnt <= 0, go to SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble ≥5 gets +3.
  - {bcd, bin_sr} shifts left by 1.
  - cnt increments.
  - When cnt == W-1 (the W-th shift), go to UPDATE.
- UPDATE:
  - Encode the three nibbles into display1..3 registers and pulse done=1.
  - Go to IDLE.
- Blanking, when BLANK_LZ=1:
  - display3 is blank if hundreds == 0.
  - display2 is blank if hundreds == 0 and tens == 0.
  - display1 is never blank.
- Outputs hold their last value between updates.
- in_valid is ignored while in_ready=0; no queueing. in_data need not be held after acceptance.
- Add-3 is a 4-bit nibble operation with no carry between nibbles. The hundreds nibble never exceeds 9 for legal W.
- Reset values:
  - state=IDLE, in_ready=1, busy=0, done=0.
  - display1=1000000 ("0").
  - display2 and display3 = 1111111 if BLANK_LZ, else 1000000.
- Asynchronous reset mid-conversion: the conversion is discarded, outputs go to reset values immediately, and no done pulse occurs.

## Timing
- Handshake at edge E0. Shifts occur at edges E1..EW.
- At edge E(W+1): displays load, done=1 for that cycle, in_ready returns to 1.
- Earliest next accept is E(W+2). Sustained period is W+2 cycles (10 for W=8).
- busy=1 from after E0 until E(W+1). in_ready = ~busy.
- done, busy, in_ready and the displays are all registered or derived from registered state. There are no combinational paths from inputs to outputs.

## Structure
- Shared package seg_pkg:
  - Ten segment-code constants plus SEG_BLANK.
  - FSM state enum (IDLE/SHIFT/UPDATE).
- Sub-module seg7_encode: combinational 4-bit digit → 7-bit active-low code. Codes 10..15 map to SEG_BLANK. Instantiated three times.
- Top module holds the FSM, bin_sr (W bits), bcd (12 bits), cnt ($clog2(W) bits) and the display registers.

## Test plan
- Reset, then hold rst_n=0 → in_ready=1, busy=0, done=0, display1=1000000, display2=display3=1111111.
- Accept 8'd255 at E0 → done high exactly after E9; display3/2/1 = 0100100/0010010/0010010 ("255"); in_ready high in the same cycle.
- Accept 8'd7 → display3=display2=1111111, display1=1111000. Repeat with BLANK_LZ=0 and 8'd5 → 1000000, 1000000, 0010010.
- Accept 8'd100, then pulse in_valid with 8'd42 during busy → 42 is ignored; displays show "100" (1111001, 1000000, 1000000); exactly one done.
- Back-to-back: in_valid held high with 8'd9, then 8'd10 → accepts 10 cycles apart; displays "  9", then " 10".
- Drive rst_n low mid-SHIFT after accepting 8'd200 → outputs return to reset values asynchronously; no done. Follow with an exhaustive sweep 0..255 checked against a reference model of digit extraction.

Source files
------------

// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment readout: segment codes, FSM states
// and the double-dabble nibble correction.
package seg_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 12;

    // Active-low codes, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Pre-shift correction so a nibble that would reach 10+ carries into the next digit
    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] nib);
        return (nib >= 4'd5) ? DIGIT_W'(nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_seg7_encode.sv
// Combinational BCD digit to active-low seven-segment code; non-decimal codes blank.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Three-digit seven-segment front-end: accepts a binary value, converts it to BCD
// one shift per clock, then updates all three displays together.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [SEG_W-1:0] display1,
    output logic [SEG_W-1:0] display2,
    output logic [SEG_W-1:0] display3
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SR_W  = BCD_W + W;
    localparam logic [SEG_W-1:0] SEG_RST_HI = BLANK_LZ ? SEG_BLANK : SEG_0;

    state_t             state;
    state_t             state_next;
    logic               load_c;
    logic               shift_c;
    logic               update_c;

    logic [W-1:0]       bin_sr;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   bcd_adj_c;
    logic [SR_W-1:0]    shifted_c;

    logic [SEG_W-1:0]   seg_ones_c;
    logic [SEG_W-1:0]   seg_tens_c;
    logic [SEG_W-1:0]   seg_hund_c;
    logic               hund_zero_c;
    logic               tens_zero_c;
    logic [SEG_W-1:0]   disp1_next_c;
    logic [SEG_W-1:0]   disp2_next_c;
    logic [SEG_W-1:0]   disp3_next_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        update_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_c     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (cnt == CNT_W'(W - 1)) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                update_c   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One double-dabble step: correct each nibble independently, then shift left
    always_comb begin
        bcd_adj_c = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        shifted_c = SR_W'({bcd_adj_c, bin_sr} << 1);
    end

    // Conversion datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
        end else if (load_c) begin
            bin_sr <= in_data;
            bcd    <= '0;
            cnt    <= '0;
        end else if (shift_c) begin
            bin_sr <= shifted_c[W-1:0];
            bcd    <= shifted_c[SR_W-1:W];
            cnt    <= CNT_W'(cnt + CNT_W'(1));
        end
    end

    seg7_encode u_enc_ones (
        .digit (bcd[3:0]),
        .seg_c (seg_ones_c)
    );

    seg7_encode u_enc_tens (
        .digit (bcd[7:4]),
        .seg_c (seg_tens_c)
    );

    seg7_encode u_enc_hund (
        .digit (bcd[11:8]),
        .seg_c (seg_hund_c)
    );

    // Leading-zero blanking; the ones digit always shows
    always_comb begin
        hund_zero_c  = (bcd[11:8] == 4'd0);
        tens_zero_c  = (bcd[7:4] == 4'd0);
        disp1_next_c = seg_ones_c;
        disp2_next_c = (BLANK_LZ && hund_zero_c && tens_zero_c) ? SEG_BLANK : seg_tens_c;
        disp3_next_c = (BLANK_LZ && hund_zero_c) ? SEG_BLANK : seg_hund_c;
    end

    // Registered status and displays; displays only change on the update cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            display1 <= SEG_0;
            display2 <= SEG_RST_HI;
            display3 <= SEG_RST_HI;
        end else begin
            in_ready <= (state_next == IDLE);
            busy     <= (state_next != IDLE);
            done     <= update_c;
            if (update_c) begin
                display1 <= disp1_next_c;
                display2 <= disp2_next_c;
                display3 <= disp3_next_c;
            end
        end
    end

endmodule
